// File: rtl/mem_loader.sv
// mem_loader: receives a byte-stream memory image and writes it word by word
// into a 2**ADDR_W-word memory while holding the processor in reset.
// Image layout: 4-byte little-endian word count N, then N little-endian words.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   in_valid   source presents a byte on in_data
//   in_data    stream byte
//   in_ready   loader accepts in_data (transfer = in_valid & in_ready)
//   reload     single-cycle pulse, restarts loading from DONE
//   mem_we     one-cycle write strobe per word
//   mem_addr   word address for mem_we
//   mem_wdata  word data for mem_we
//   cpu_hold   holds processor in reset while loading
//   done       image fully received
//   err        header count exceeded memory depth (sticky until reset/reload)
module mem_loader #(
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   localparam logic [32:0] DEPTH = 33'(1) << ADDR_W;

   typedef enum logic [1:0] {
      S_HDR  = 2'd0,
      S_DATA = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [1:0]        r_byte_cnt;
   logic [31:0]       r_shift;
   logic [31:0]       r_n;
   logic [31:0]       r_word_cnt;
   logic              r_in_ready;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic              r_cpu_hold;
   logic              r_done;
   logic              r_err;

   logic              w_xfer;
   logic              w_last_byte;
   logic [31:0]       w_word;
   logic [31:0]       w_word_cnt_nxt;
   logic              w_in_range;

   // New bytes enter at the top so the first byte ends up in bits 7:0.
   assign w_xfer         = in_valid & r_in_ready;
   assign w_last_byte    = (r_byte_cnt == 2'd3);
   assign w_word         = {in_data, r_shift[31:8]};
   assign w_word_cnt_nxt = r_word_cnt + 32'd1;
   assign w_in_range     = ({1'b0, r_word_cnt} < DEPTH);

   // Loader FSM with registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_HDR;
         r_byte_cnt  <= 2'd0;
         r_shift     <= 32'd0;
         r_n         <= 32'd0;
         r_word_cnt  <= 32'd0;
         r_in_ready  <= 1'b1;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 32'd0;
         r_cpu_hold  <= 1'b1;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_mem_we <= 1'b0;
         case (r_state)
            S_HDR: begin
               if (w_xfer) begin
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (w_last_byte) begin
                     r_n        <= w_word;
                     r_shift    <= 32'd0;
                     r_word_cnt <= 32'd0;
                     if (w_word == 32'd0) begin
                        r_state    <= S_DONE;
                        r_in_ready <= 1'b0;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                     end else begin
                        r_state <= S_DATA;
                        r_err   <= ({1'b0, w_word} > DEPTH);
                     end
                  end else begin
                     r_shift <= w_word;
                  end
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (w_last_byte) begin
                     r_shift    <= 32'd0;
                     r_word_cnt <= w_word_cnt_nxt;
                     // Words beyond the memory depth are consumed but dropped.
                     if (w_in_range) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_word_cnt[ADDR_W-1:0];
                        r_mem_wdata <= w_word;
                     end
                     if (w_word_cnt_nxt == r_n) begin
                        r_state    <= S_DONE;
                        r_in_ready <= 1'b0;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                     end
                  end else begin
                     r_shift <= w_word;
                  end
               end
            end
            S_DONE: begin
               if (reload) begin
                  r_state    <= S_HDR;
                  r_in_ready <= 1'b1;
                  r_done     <= 1'b0;
                  r_cpu_hold <= 1'b1;
                  r_err      <= 1'b0;
                  r_byte_cnt <= 2'd0;
                  r_shift    <= 32'd0;
                  r_n        <= 32'd0;
                  r_word_cnt <= 32'd0;
               end
            end
            default: begin
               r_state <= S_HDR;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign cpu_hold  = r_cpu_hold;
   assign done      = r_done;
   assign err       = r_err;

endmodule

// File: tb/tb_mem_loader.sv
// Directed testbench for mem_loader (instantiated with a 4-word memory so the
// depth-overflow behaviour is reachable with short images).
module tb_mem_loader;

   localparam int unsigned ADDR_W = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              reload = 1'b0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [ADDR_W-1:0] wr_addr[$];
   logic [31:0]       wr_data[$];
   int                wr_cyc[$];

   mem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .reload    (reload),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Write log, sampled on the falling edge; cyc numbers each cycle.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (mem_we === 1'b1) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
         wr_cyc.push_back(cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
   endtask

   // Offer one byte; acc receives the cycle index in which a resulting write would appear.
   task automatic send_byte(input logic [7:0] b, output int acc);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_before_byte got=%b exp=1", in_ready);
      end
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #1;
      acc      = cyc + 1;
      in_valid = 1'b0;
      in_data  = 8'h5A;
   endtask

   task automatic send_word(input logic [31:0] w, output int acc);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], acc);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reload   = 1'b0;
      reset    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      clear_log();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (mem_we !== 1'b0)       begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
      checks++; if (mem_addr !== 2'd0)     begin failures++; $display("FAIL rst_mem_addr got=%0d exp=0", mem_addr); end
      checks++; if (mem_wdata !== 32'd0)   begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
      checks++; if (cpu_hold !== 1'b1)     begin failures++; $display("FAIL rst_cpu_hold got=%b exp=1", cpu_hold); end
      checks++; if (done !== 1'b0)         begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
      checks++; if (err !== 1'b0)          begin failures++; $display("FAIL rst_err got=%b exp=0", err); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1)     begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      clear_log();
   endtask

   task automatic test_basic();
      int a, a0, a1;
      do_reset();
      send_word(32'h0000_0002, a);
      checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL basic_hdr hold=%b done=%b err=%b exp 1 0 0", cpu_hold, done, err); end
      send_word(32'h1234_5678, a0);
      checks++; if (mem_we !== 1'b1)       begin failures++; $display("FAIL basic_we0 got=%b exp=1", mem_we); end
      send_word(32'hDEAD_BEEF, a1);
      checks++; if (done !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL basic_done_with_we done=%b we=%b exp 1 1", done, mem_we); end
      checks++; if (cpu_hold !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL basic_done_outs hold=%b ready=%b exp 0 0", cpu_hold, in_ready); end
      idle(1);
      checks++; if (mem_we !== 1'b0 || mem_addr !== 2'd1 || mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL basic_hold we=%b addr=%0d data=%h exp 0 1 deadbeef", mem_we, mem_addr, mem_wdata); end
      // Bytes offered in DONE are refused.
      in_valid = 1'b1;
      in_data  = 8'h99;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL basic_done_refuse ready=%b done=%b exp 0 1", in_ready, done); end
      checks++; if (wr_addr.size() != 2)  begin failures++; $display("FAIL basic_nwrites got=%0d exp=2", wr_addr.size()); end
      else begin
         checks++; if (wr_addr[0] !== 2'd0 || wr_data[0] !== 32'h1234_5678 || wr_cyc[0] != a0) begin failures++; $display("FAIL basic_w0 addr=%0d data=%h cyc=%0d exp 0 12345678 %0d", wr_addr[0], wr_data[0], wr_cyc[0], a0); end
         checks++; if (wr_addr[1] !== 2'd1 || wr_data[1] !== 32'hDEAD_BEEF || wr_cyc[1] != a1) begin failures++; $display("FAIL basic_w1 addr=%0d data=%h cyc=%0d exp 1 deadbeef %0d", wr_addr[1], wr_data[1], wr_cyc[1], a1); end
      end
   endtask

   task automatic test_zero();
      int a;
      do_reset();
      send_word(32'h0000_0000, a);
      checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL zero_done done=%b hold=%b ready=%b exp 1 0 0", done, cpu_hold, in_ready); end
      checks++; if (err !== 1'b0)          begin failures++; $display("FAIL zero_err got=%b exp=0", err); end
      idle(3);
      checks++; if (wr_addr.size() != 0)  begin failures++; $display("FAIL zero_nwrites got=%0d exp=0", wr_addr.size()); end
   endtask

   task automatic test_full_depth();
      int a;
      int acc[4];
      do_reset();
      send_word(32'h0000_0004, a);
      checks++; if (err !== 1'b0)          begin failures++; $display("FAIL full_err got=%b exp=0", err); end
      for (int i = 0; i < 4; i++) send_word(32'hA5A5_0000 | 32'(i), acc[i]);
      idle(2);
      checks++; if (done !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL full_end done=%b err=%b exp 1 0", done, err); end
      checks++; if (wr_addr.size() != 4)  begin failures++; $display("FAIL full_nwrites got=%0d exp=4", wr_addr.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (wr_addr[i] !== 2'(i) || wr_data[i] !== (32'hA5A5_0000 | 32'(i)) || wr_cyc[i] != acc[i]) begin failures++; $display("FAIL full_w%0d addr=%0d data=%h cyc=%0d exp %0d %h %0d", i, wr_addr[i], wr_data[i], wr_cyc[i], i, 32'hA5A5_0000 | 32'(i), acc[i]); end
         end
      end
   endtask

   task automatic test_overflow();
      int a;
      int acc[5];
      do_reset();
      send_word(32'h0000_0005, a);
      checks++; if (err !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL ovf_err_entry err=%b done=%b exp 1 0", err, done); end
      for (int i = 0; i < 5; i++) send_word(32'hC0DE_0000 | 32'(i), acc[i]);
      checks++; if (mem_we !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL ovf_last we=%b done=%b exp 0 1", mem_we, done); end
      idle(2);
      checks++; if (err !== 1'b1)          begin failures++; $display("FAIL ovf_err_sticky got=%b exp=1", err); end
      checks++; if (mem_addr !== 2'd3 || mem_wdata !== 32'hC0DE_0003) begin failures++; $display("FAIL ovf_hold addr=%0d data=%h exp 3 c0de0003", mem_addr, mem_wdata); end
      checks++; if (wr_addr.size() != 4)  begin failures++; $display("FAIL ovf_nwrites got=%0d exp=4", wr_addr.size()); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (wr_addr[i] !== 2'(i) || wr_data[i] !== (32'hC0DE_0000 | 32'(i)) || wr_cyc[i] != acc[i]) begin failures++; $display("FAIL ovf_w%0d addr=%0d data=%h cyc=%0d", i, wr_addr[i], wr_data[i], wr_cyc[i]); end
         end
      end
   endtask

   // Runs from the DONE state left by test_overflow (err still set).
   task automatic test_reload();
      int a;
      reload   = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h07;
      checks++; if (in_ready !== 1'b0)     begin failures++; $display("FAIL reload_ready_same got=%b exp=0", in_ready); end
      @(posedge clk);
      #1;
      reload   = 1'b0;
      in_valid = 1'b0;
      checks++; if (done !== 1'b0 || cpu_hold !== 1'b1 || err !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL reload_state done=%b hold=%b err=%b ready=%b exp 0 1 0 1", done, cpu_hold, err, in_ready); end
      clear_log();
      send_word(32'h0000_0001, a);
      send_word(32'h89AB_CDEF, a);
      idle(2);
      checks++; if (done !== 1'b1)         begin failures++; $display("FAIL reload_done got=%b exp=1", done); end
      checks++; if (wr_addr.size() != 1)  begin failures++; $display("FAIL reload_nwrites got=%0d exp=1", wr_addr.size()); end
      else begin
         checks++; if (wr_addr[0] !== 2'd0 || wr_data[0] !== 32'h89AB_CDEF || wr_cyc[0] != a) begin failures++; $display("FAIL reload_w0 addr=%0d data=%h cyc=%0d exp 0 89abcdef %0d", wr_addr[0], wr_data[0], wr_cyc[0], a); end
      end
   endtask

   task automatic test_gaps();
      int a;
      logic [7:0] bytes[8];
      bytes = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         send_byte(bytes[i], a);
         if (i == 7) begin
            checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL gaps_we got=%b exp=1", mem_we); end
         end
         in_data = 8'hFF;
         idle(1);
      end
      idle(2);
      checks++; if (done !== 1'b1)         begin failures++; $display("FAIL gaps_done got=%b exp=1", done); end
      checks++; if (wr_addr.size() != 1)  begin failures++; $display("FAIL gaps_nwrites got=%0d exp=1", wr_addr.size()); end
      else begin
         checks++; if (wr_addr[0] !== 2'd0 || wr_data[0] !== 32'hCAFE_F00D || wr_cyc[0] != a) begin failures++; $display("FAIL gaps_w0 addr=%0d data=%h cyc=%0d exp 0 cafef00d %0d", wr_addr[0], wr_data[0], wr_cyc[0], a); end
      end
   endtask

   task automatic test_reset_mid();
      int a;
      do_reset();
      send_word(32'h0000_0003, a);
      send_word(32'h1122_3344, a);
      send_byte(8'hAA, a);
      send_byte(8'hBB, a);
      clear_log();
      reset = 1'b0;
      #1;
      checks++; if (mem_we !== 1'b0 || mem_addr !== 2'd0 || mem_wdata !== 32'd0) begin failures++; $display("FAIL mid_rst_mem we=%b addr=%0d data=%h exp 0 0 0", mem_we, mem_addr, mem_wdata); end
      checks++; if (cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ctl hold=%b done=%b err=%b ready=%b exp 1 0 0 1", cpu_hold, done, err, in_ready); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      idle(4);
      checks++; if (wr_addr.size() != 0)  begin failures++; $display("FAIL mid_no_partial_write got=%0d exp=0", wr_addr.size()); end
      send_word(32'h0000_0001, a);
      send_word(32'h0BAD_F00D, a);
      idle(2);
      checks++; if (done !== 1'b1)         begin failures++; $display("FAIL mid_done got=%b exp=1", done); end
      checks++; if (wr_addr.size() != 1)  begin failures++; $display("FAIL mid_nwrites got=%0d exp=1", wr_addr.size()); end
      else begin
         checks++; if (wr_addr[0] !== 2'd0 || wr_data[0] !== 32'h0BAD_F00D) begin failures++; $display("FAIL mid_w0 addr=%0d data=%h exp 0 0badf00d", wr_addr[0], wr_data[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_full_depth();
      test_overflow();
      test_reload();
      test_gaps();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
